dmi_req_sync_ctrl: RTL and testbench
====================================

Name: dmi_req_sync_ctrl

Overview:
- Core-clock-domain successor to the single-bit DMI jtag-to-core synchronizer.
- Synchronizes TAP read/write strobes into `clk` with a parametrised number of stages, then captures address and data.
- Issues one request at a time to the debug module over a valid/ready handshake and waits for a response.
- Returns read data plus DMI status (ok / failed / busy) to the TAP, with sticky-error and overrun semantics per debug spec 0.13.

Parameters:
- ADDR_WIDTH, 7, DMI address width.
- DATA_WIDTH, 32, DMI data width.
- SYNC_STAGES, 2, flops per strobe synchronizer; legal range 2..4.
- TIMEOUT_CYCLES, 255, response timeout in `clk` cycles; used only with DMI_RSP_TIMEOUT_EN; legal range 1..65535.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- jtag_wr_en  in  1  TAP write strobe, asynchronous to `clk`.
- jtag_rd_en  in  1  TAP read strobe, asynchronous to `clk`.
- jtag_addr  in  ADDR_WIDTH  TAP address; quasi-static, stable from strobe rise until the next strobe.
- jtag_wdata  in  DATA_WIDTH  TAP write data; quasi-static.
- jtag_dmi_reset  in  1  TAP dmireset level, asynchronous; clears sticky status.
- core_req_valid  out  1  request valid to debug module.
- core_req_write  out  1  1 = write, 0 = read.
- core_req_addr  out  ADDR_WIDTH  request address.
- core_req_wdata  out  DATA_WIDTH  request write data.
- core_req_ready  in  1  debug module accepts request.
- core_rsp_valid  in  1  response valid.
- core_rsp_data  in  DATA_WIDTH  read response data.
- core_rsp_err  in  1  response error.
- rsp_rdata  out  DATA_WIDTH  last successful read data, to TAP.
- dmi_stat  out  2  00 ok, 10 failed, 11 busy/overrun; sticky.
- busy  out  1  high while in REQ or WAIT_RSP.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; all synchronizer and edge-detect flops 0.
- Strobe synchronizers: `jtag_wr_en`, `jtag_rd_en` and `jtag_dmi_reset` each pass through SYNC_STAGES flops.
  - A rising edge is detected from the last stage vs. one additional history flop.
  - Edge 1 is the first `clk` edge sampling a high strobe. `core_req_valid` rises after edge SYNC_STAGES+1.
- Simultaneous wr and rd edges in the same cycle: treated as a write.
- States:
  - IDLE. On a strobe edge with `dmi_stat`==00: capture `jtag_addr`/`jtag_wdata` into `core_req_*`, set `core_req_write`, assert `core_req_valid`, go to REQ.
  - IDLE. On a strobe edge with `dmi_stat`!=00: request dropped, stay in IDLE.
  - REQ. Hold `core_req_valid` and the payload stable until `core_req_valid`&`core_req_ready`. On that cycle deassert valid and go to WAIT_RSP.
  - WAIT_RSP. On `core_rsp_valid`:
    - If `core_rsp_err`=1: `dmi_stat`<=10 if it was 00.
    - Else if the request was a read: `rsp_rdata`<=`core_rsp_data`.
    - Return to IDLE.
- `core_rsp_valid` outside WAIT_RSP is ignored. A response is accepted at the earliest on the cycle after the request is accepted.
- Writes never modify `rsp_rdata`. An errored read leaves `rsp_rdata` unchanged.
- Overrun: a strobe edge while in REQ or WAIT_RSP is dropped. `dmi_stat`<=11 if it was 00. The in-flight request completes normally.
- Sticky status: the first nonzero `dmi_stat` value wins. A synchronized `jtag_dmi_reset` rising edge clears `dmi_stat` to 00 and does not affect the FSM or in-flight traffic.
- Simultaneous events in one cycle, highest priority first: `dmi_reset` clear, then new error/overrun set. The clear wins, so the stat ends at 00.
- `busy` = (state != IDLE), registered with the state.
- Reset mid-operation: assertion of `rst_n` immediately forces the reset values; the in-flight request is abandoned.

Optional Feature:
- Macro: DMI_RSP_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT_RSP and increments each WAIT_RSP cycle without `core_rsp_valid`.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, `dmi_stat`<=10 if it was 00, `rsp_rdata` unchanged.
  - A response arriving in the same cycle as the timeout wins.
- Undefined: no counter; WAIT_RSP waits indefinitely.

Test Plan:
- Read, SYNC_STAGES=2: `jtag_addr`=0x11, pulse `jtag_rd_en`; `core_req_ready`=1; response data 0xDEADBEEF one cycle later -> `core_req_valid` high after edge 3 for 1 cycle, `core_req_write`=0, `core_req_addr`=0x11, `rsp_rdata`=0xDEADBEEF, `dmi_stat`=00, `busy` low afterwards.
- Write with backpressure: `jtag_wdata`=0x12345678, `core_req_ready` low 5 cycles -> valid and payload held 5 cycles, accepted on cycle 6; `rsp_rdata` unchanged.
- Error response: `core_rsp_err`=1 -> `dmi_stat`=10; next read strobe dropped (no `core_req_valid`); `jtag_dmi_reset` pulse -> `dmi_stat`=00; next read issues normally.
- Overrun: second `jtag_wr_en` pulse while in WAIT_RSP -> `dmi_stat`=11, exactly one core request seen; a later error response leaves `dmi_stat`=11.
- Simultaneous `jtag_wr_en` and `jtag_rd_en` rise -> single request with `core_req_write`=1.
- With DMI_RSP_TIMEOUT_EN, TIMEOUT_CYCLES=8: no response -> IDLE after 8 WAIT_RSP cycles, `dmi_stat`=10. Also assert `rst_n` low mid-REQ -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dmi_req_sync_ctrl.sv
// DMI request controller: synchronizes TAP strobes into clk, issues one debug-module request at a time.
// Optional response timeout enabled by defining DMI_RSP_TIMEOUT_EN.
module dmi_req_sync_ctrl #(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  jtag_wr_en,
    input  logic                  jtag_rd_en,
    input  logic [ADDR_WIDTH-1:0] jtag_addr,
    input  logic [DATA_WIDTH-1:0] jtag_wdata,
    input  logic                  jtag_dmi_reset,
    output logic                  core_req_valid,
    output logic                  core_req_write,
    output logic [ADDR_WIDTH-1:0] core_req_addr,
    output logic [DATA_WIDTH-1:0] core_req_wdata,
    input  logic                  core_req_ready,
    input  logic                  core_rsp_valid,
    input  logic [DATA_WIDTH-1:0] core_rsp_data,
    input  logic                  core_rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            dmi_stat,
    output logic                  busy
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("dmi_req_sync_ctrl: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    localparam logic [1:0] STAT_OK     = 2'b00;
    localparam logic [1:0] STAT_FAILED = 2'b10;
    localparam logic [1:0] STAT_BUSY   = 2'b11;

    logic [SYNC_STAGES-1:0] wr_sync_q, rd_sync_q, clr_sync_q;
    logic                   wr_hist_q, rd_hist_q, clr_hist_q;
    logic                   wr_edge, rd_edge, clr_edge, strobe_edge;

    state_e                 state_q;
    logic                   req_valid_q, req_write_q, busy_q;
    logic [ADDR_WIDTH-1:0]  req_addr_q;
    logic [DATA_WIDTH-1:0]  req_wdata_q, rdata_q;
    logic [1:0]             stat_q, stat_d;
    logic                   err_evt, ovr_evt, timeout_evt;

    // Each strobe gets its own synchronizer chain plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sync_q  <= '0;
            rd_sync_q  <= '0;
            clr_sync_q <= '0;
            wr_hist_q  <= 1'b0;
            rd_hist_q  <= 1'b0;
            clr_hist_q <= 1'b0;
        end else begin
            wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], jtag_wr_en};
            rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0], jtag_rd_en};
            clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], jtag_dmi_reset};
            wr_hist_q  <= wr_sync_q[SYNC_STAGES-1];
            rd_hist_q  <= rd_sync_q[SYNC_STAGES-1];
            clr_hist_q <= clr_sync_q[SYNC_STAGES-1];
        end
    end

    assign wr_edge     = wr_sync_q[SYNC_STAGES-1] & ~wr_hist_q;
    assign rd_edge     = rd_sync_q[SYNC_STAGES-1] & ~rd_hist_q;
    assign clr_edge    = clr_sync_q[SYNC_STAGES-1] & ~clr_hist_q;
    assign strobe_edge = wr_edge | rd_edge;

`ifdef DMI_RSP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt_q;

    // Held at zero while the request is pending so it starts clean on entry to WAIT_RSP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q != WAIT_RSP) begin
            to_cnt_q <= '0;
        end else if (!core_rsp_valid) begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_evt = (state_q == WAIT_RSP) && !core_rsp_valid && (to_cnt_q == CNT_LAST);
`else
    assign timeout_evt = 1'b0;
`endif

    assign err_evt = ((state_q == WAIT_RSP) && core_rsp_valid && core_rsp_err) || timeout_evt;
    assign ovr_evt = strobe_edge && (state_q != IDLE);

    // Sticky status: a dmireset edge always wins, otherwise only the first nonzero value is kept.
    always_comb begin
        stat_d = stat_q;
        if (clr_edge) begin
            stat_d = STAT_OK;
        end else if (stat_q == STAT_OK) begin
            if (err_evt) begin
                stat_d = STAT_FAILED;
            end else if (ovr_evt) begin
                stat_d = STAT_BUSY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            stat_q      <= STAT_OK;
            busy_q      <= 1'b0;
        end else begin
            stat_q <= stat_d;
            case (state_q)
                IDLE: begin
                    if (strobe_edge && (stat_q == STAT_OK)) begin
                        req_addr_q  <= jtag_addr;
                        req_wdata_q <= jtag_wdata;
                        req_write_q <= wr_edge;
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (core_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (core_rsp_valid) begin
                        if (!core_rsp_err && !req_write_q) begin
                            rdata_q <= core_rsp_data;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (timeout_evt) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign core_req_valid = req_valid_q;
    assign core_req_write = req_write_q;
    assign core_req_addr  = req_addr_q;
    assign core_req_wdata = req_wdata_q;
    assign rsp_rdata      = rdata_q;
    assign dmi_stat       = stat_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_dmi_req_sync_ctrl.sv
// Directed, table-driven bench for dmi_req_sync_ctrl; timeout sequence runs only with DMI_RSP_TIMEOUT_EN.
module tb_dmi_req_sync_ctrl;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int SS = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          jtag_wr_en = 1'b0;
    logic          jtag_rd_en = 1'b0;
    logic [AW-1:0] jtag_addr = '0;
    logic [DW-1:0] jtag_wdata = '0;
    logic          jtag_dmi_reset = 1'b0;
    logic          core_req_valid;
    logic          core_req_write;
    logic [AW-1:0] core_req_addr;
    logic [DW-1:0] core_req_wdata;
    logic          core_req_ready = 1'b0;
    logic          core_rsp_valid = 1'b0;
    logic [DW-1:0] core_rsp_data = '0;
    logic          core_rsp_err = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    dmi_stat;
    logic          busy;

    int checkCount = 0;
    int errorCount = 0;
    int acceptCount = 0;

    always #5 clk = ~clk;

    dmi_req_sync_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .jtag_wr_en(jtag_wr_en), .jtag_rd_en(jtag_rd_en),
        .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
        .jtag_dmi_reset(jtag_dmi_reset),
        .core_req_valid(core_req_valid), .core_req_write(core_req_write),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_req_ready(core_req_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_err(core_rsp_err),
        .rsp_rdata(rsp_rdata), .dmi_stat(dmi_stat), .busy(busy)
    );

    always @(posedge clk) begin
        if (core_req_valid && core_req_ready) acceptCount <= acceptCount + 1;
    end

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic          clr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    rdyDly;
        logic          err;
        logic [DW-1:0] rspData;
        logic          expReq;
        logic          expWrite;
        logic [DW-1:0] expRdata;
        logic [1:0]    expStat;
    } vec_t;

    vec_t vecs[10];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulseDmiReset();
        @(negedge clk);
        jtag_dmi_reset = 1'b1;
        repeat (4) @(negedge clk);
        jtag_dmi_reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (core_req_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("vec%0d busy", idx), busy, 0);
        checkVal($sformatf("vec%0d rsp_rdata", idx), rsp_rdata, v.expRdata);
        checkVal($sformatf("vec%0d dmi_stat", idx), dmi_stat, v.expStat);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int lat;
        if (v.clr) pulseDmiReset();
        @(negedge clk);
        jtag_addr  = v.addr;
        jtag_wdata = v.wdata;
        jtag_wr_en = v.wr;
        jtag_rd_en = v.rd;
        waitValid(lat);
        jtag_wr_en = 1'b0;
        jtag_rd_en = 1'b0;
        if (!v.expReq) begin
            checkVal($sformatf("vec%0d dropped no valid", idx), lat, 0);
            repeat (4) @(negedge clk);
            checkOutput(v, idx);
            return;
        end
        checkVal($sformatf("vec%0d latency", idx), lat, SS + 1);
        checkVal($sformatf("vec%0d write", idx), core_req_write, v.expWrite);
        checkVal($sformatf("vec%0d addr", idx), core_req_addr, v.addr);
        checkVal($sformatf("vec%0d wdata", idx), core_req_wdata, v.wdata);
        for (int i = 0; i < int'(v.rdyDly); i++) begin
            checkVal($sformatf("vec%0d hold valid", idx), core_req_valid, 1);
            checkVal($sformatf("vec%0d hold addr", idx), core_req_addr, v.addr);
            checkVal($sformatf("vec%0d hold wdata", idx), core_req_wdata, v.wdata);
            @(negedge clk);
        end
        core_req_ready = 1'b1;
        @(negedge clk);
        core_req_ready = 1'b0;
        checkVal($sformatf("vec%0d valid after accept", idx), core_req_valid, 0);
        checkVal($sformatf("vec%0d busy in wait", idx), busy, 1);
        core_rsp_valid = 1'b1;
        core_rsp_err   = v.err;
        core_rsp_data  = v.rspData;
        @(negedge clk);
        core_rsp_valid = 1'b0;
        core_rsp_err   = 1'b0;
        checkOutput(v, idx);
    endtask

    // Start a request and walk it to WAIT_RSP with no response.
    task automatic issueToWait(input logic isWrite, input logic [AW-1:0] addr, input string name);
        int lat;
        @(negedge clk);
        jtag_addr  = addr;
        jtag_wr_en = isWrite;
        jtag_rd_en = !isWrite;
        waitValid(lat);
        jtag_wr_en = 1'b0;
        jtag_rd_en = 1'b0;
        checkVal({name, " latency"}, lat, SS + 1);
        core_req_ready = 1'b1;
        @(negedge clk);
        core_req_ready = 1'b0;
        checkVal({name, " busy in wait"}, busy, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int lat;
        int baseAcc;
        int k;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 7'h11, 32'h0,        4'd0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 7'h22, 32'h12345678, 4'd5, 1'b0, 32'hAAAA5555, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 7'h05, 32'h0,        4'd0, 1'b1, 32'h0BADF00D, 1'b1, 1'b0, 32'hDEADBEEF, 2'b10};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 7'h06, 32'h0,        4'd0, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'hDEADBEEF, 2'b10};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 7'h07, 32'h0,        4'd2, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 2'b00};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 7'h33, 32'h0F0F0F0F, 4'd0, 1'b0, 32'h22222222, 1'b1, 1'b1, 32'hCAFEF00D, 2'b00};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 7'h7F, 32'h0,        4'd1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 2'b00};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 7'h01, 32'hA5A5A5A5, 4'd0, 1'b1, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFF, 2'b10};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 7'h02, 32'h0,        4'd0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFFFFFF, 2'b10};
        vecs[9] = '{1'b1, 1'b0, 1'b1, 7'h00, 32'h0,        4'd0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFF, 2'b00};

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("reset ctrl outputs", {core_req_valid, core_req_write, busy, dmi_stat}, 0);
        checkVal("reset addr", core_req_addr, 0);
        checkVal("reset wdata", core_req_wdata, 0);
        checkVal("reset rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

        // Response during REQ is ignored, then overrun while waiting, then a late error keeps 11.
        baseAcc = acceptCount;
        @(negedge clk);
        jtag_addr  = 7'h40;
        jtag_wdata = 32'h55AA55AA;
        jtag_wr_en = 1'b1;
        waitValid(lat);
        jtag_wr_en = 1'b0;
        checkVal("ovr latency", lat, SS + 1);
        core_rsp_valid = 1'b1;
        core_rsp_err   = 1'b1;
        repeat (2) @(negedge clk);
        checkVal("rsp ignored in REQ valid", core_req_valid, 1);
        checkVal("rsp ignored in REQ stat", dmi_stat, 0);
        core_rsp_valid = 1'b0;
        core_rsp_err   = 1'b0;
        core_req_ready = 1'b1;
        @(negedge clk);
        core_req_ready = 1'b0;
        checkVal("ovr busy in wait", busy, 1);
        @(negedge clk);
        jtag_wr_en = 1'b1;
        repeat (3) @(negedge clk);
        jtag_wr_en = 1'b0;
        @(negedge clk);
        checkVal("overrun stat", dmi_stat, 2'b11);
        checkVal("overrun still busy", busy, 1);
        core_rsp_valid = 1'b1;
        core_rsp_err   = 1'b1;
        @(negedge clk);
        core_rsp_valid = 1'b0;
        core_rsp_err   = 1'b0;
        checkVal("ovr done busy", busy, 0);
        checkVal("error after overrun stat", dmi_stat, 2'b11);
        repeat (4) @(negedge clk);
        checkVal("overrun single request", acceptCount - baseAcc, 1);
        checkVal("overrun no extra valid", core_req_valid, 0);
        pulseDmiReset();
        checkVal("stat cleared after overrun", dmi_stat, 0);

        // dmireset edge and an error response land on the same clock edge: clear wins.
        issueToWait(1'b0, 7'h12, "clr-vs-err");
        jtag_dmi_reset = 1'b1;
        repeat (SS) @(negedge clk);
        core_rsp_valid = 1'b1;
        core_rsp_err   = 1'b1;
        @(negedge clk);
        core_rsp_valid = 1'b0;
        core_rsp_err   = 1'b0;
        jtag_dmi_reset = 1'b0;
        checkVal("clr-vs-err stat", dmi_stat, 0);
        checkVal("clr-vs-err busy", busy, 0);
        checkVal("clr-vs-err rdata", rsp_rdata, 32'hFFFFFFFF);
        repeat (4) @(negedge clk);

`ifdef DMI_RSP_TIMEOUT_EN
        issueToWait(1'b0, 7'h21, "timeout");
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!busy) begin
                k = c;
                break;
            end
        end
        checkVal("timeout wait cycles", k, TO);
        checkVal("timeout stat", dmi_stat, 2'b10);
        checkVal("timeout rdata", rsp_rdata, 32'hFFFFFFFF);
        pulseDmiReset();
`else
        k = 0;
`endif

        // Asynchronous reset while a request is pending.
        @(negedge clk);
        jtag_addr  = 7'h7F;
        jtag_wdata = 32'hFFFFFFFF;
        jtag_wr_en = 1'b1;
        waitValid(lat);
        jtag_wr_en = 1'b0;
        checkVal("mid-REQ valid before reset", core_req_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        checkVal("async reset ctrl", {core_req_valid, core_req_write, busy, dmi_stat}, 0);
        checkVal("async reset addr", core_req_addr, 0);
        checkVal("async reset wdata", core_req_wdata, 0);
        checkVal("async reset rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkVal("after reset idle", {core_req_valid, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
